mvp_pll_switch_ctrl: RTL

Upstream sequencer for the MVP PLL state machine. It accepts VCO-change requests from the frequency-change controller over a req/ack handshake. It drives core_vco_sel and core_switch_vco into mvp_pll_sm, then tracks the PLL through ready/switch_done to completion, with a programmable timeout. It also counts PLL loss-of-lock events for status CSRs.

---
 rtl/mvp_pll_pkg.sv | 22 ++
 rtl/mvp_pll_switch_ctrl_if.sv | 36 +++
 rtl/mvp_pll_sat_cnt.sv | 37 +++
 rtl/mvp_pll_switch_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/mvp_pll_pkg.sv
// Shared state and VCO encodings for the MVP PLL switch sequencer.
// Latency: n/a (types only); backpressure: n/a.
package mvp_pll_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SETUP      = 3'd1,
        SWITCH_REQ = 3'd2,
        WAIT_DONE  = 3'd3,
        COMPLETE   = 3'd4
    } sw_state_t;

    localparam logic [1:0] VCO0        = 2'd0;
    localparam logic [1:0] VCO1        = 2'd1;
    localparam logic [1:0] VCO2        = 2'd2;
    localparam logic [1:0] VCO_ILLEGAL = 2'd3;

    function automatic logic vco_legal(input logic [1:0] vco);
        return vco != VCO_ILLEGAL;
    endfunction

endpackage

// File: rtl/mvp_pll_switch_ctrl_if.sv
// Request, PLL status/control, CSR and status bundle of the switch sequencer.
// Latency: n/a (wires only); backpressure: req is held by the requester until ack.
interface mvp_pll_switch_ctrl_if #(
    parameter int TMO_W = 16,
    parameter int LOL_W = 8
);
    logic              req;
    logic [1:0]        req_vco;
    logic              ack;
    logic              ack_err;
    logic              busy;
    logic              pll_ready;
    logic              pll_switch_done;
    logic [1:0]        pll_vco_sel;
    logic              pll_loss_of_lock;
    logic [1:0]        core_vco_sel;
    logic              core_switch_vco;
    logic [3:0]        swi_setup_count;
    logic [TMO_W-1:0]  swi_switch_timeout;
    logic              swi_lol_clr;
    logic [LOL_W-1:0]  lol_count;
    logic [2:0]        switch_fsm_state;

    modport master (
        output req, req_vco, pll_ready, pll_switch_done, pll_vco_sel, pll_loss_of_lock,
               swi_setup_count, swi_switch_timeout, swi_lol_clr,
        input  ack, ack_err, busy, core_vco_sel, core_switch_vco, lol_count, switch_fsm_state
    );

    modport slave (
        input  req, req_vco, pll_ready, pll_switch_done, pll_vco_sel, pll_loss_of_lock,
               swi_setup_count, swi_switch_timeout, swi_lol_clr,
        output ack, ack_err, busy, core_vco_sel, core_switch_vco, lol_count, switch_fsm_state
    );

endinterface

// File: rtl/mvp_pll_sat_cnt.sv
// Saturating up-counter with clear; clear wins over increment.
// Latency: 1 cycle inc/clr to output; backpressure: none.
module mvp_pll_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mvp_pll_switch_ctrl.sv
// Sequences VCO-change requests into mvp_pll_sm and counts loss-of-lock events.
// Latency: switch asserts setup_count+1 cycles after accept; backpressure: req waits in IDLE until pll_ready.
module mvp_pll_switch_ctrl
    import mvp_pll_pkg::*;
#(
    parameter int TMO_W = 16,
    parameter int LOL_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    mvp_pll_switch_ctrl_if.slave  bus
);

    sw_state_t        state_q, state_d;
    logic [1:0]       vco_q, vco_d;
    logic             sw_q, sw_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
    logic             ack_err_q, ack_err_d;
    logic             tmr_inc, tmr_clr;
    logic             tmo_hit;
    logic [TMO_W-1:0] tmr_q;
    logic [LOL_W-1:0] lol_q;

    mvp_pll_sat_cnt #(.W(TMO_W)) u_tmr (
        .clk   (clk),
        .rst   (reset),
        .inc_i (tmr_inc),
        .clr_i (tmr_clr),
        .cnt_o (tmr_q)
    );

    mvp_pll_sat_cnt #(.W(LOL_W)) u_lol (
        .clk   (clk),
        .rst   (reset),
        .inc_i (bus.pll_loss_of_lock),
        .clr_i (bus.swi_lol_clr),
        .cnt_o (lol_q)
    );

    // A zero timeout disables the check; the saturated timer then just sits at max.
    assign tmo_hit = (bus.swi_switch_timeout != '0) && (tmr_q == bus.swi_switch_timeout);

    always_comb begin
        state_d   = state_q;
        vco_d     = vco_q;
        sw_d      = sw_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        ack_d     = 1'b0;
        ack_err_d = 1'b0;
        tmr_inc   = 1'b0;
        tmr_clr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req && bus.pll_ready) begin
                    busy_d = 1'b1;
                    if (!vco_legal(bus.req_vco)) begin
                        state_d   = COMPLETE;
                        ack_d     = 1'b1;
                        ack_err_d = 1'b1;
                    end else if (bus.req_vco == bus.pll_vco_sel) begin
                        state_d = COMPLETE;
                        ack_d   = 1'b1;
                    end else begin
                        vco_d   = bus.req_vco;
                        cnt_d   = 4'd0;
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                if (cnt_q == bus.swi_setup_count) begin
                    sw_d    = 1'b1;
                    tmr_clr = 1'b1;
                    state_d = SWITCH_REQ;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            SWITCH_REQ: begin
                tmr_inc = 1'b1;
                if (tmo_hit) begin
                    sw_d      = 1'b0;
                    state_d   = COMPLETE;
                    ack_d     = 1'b1;
                    ack_err_d = 1'b1;
                end else if (!bus.pll_ready) begin
                    sw_d    = 1'b0;
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                tmr_inc = 1'b1;
                // switch_done while still LOCKING (ready low) is not completion.
                if (tmo_hit) begin
                    sw_d      = 1'b0;
                    state_d   = COMPLETE;
                    ack_d     = 1'b1;
                    ack_err_d = 1'b1;
                end else if (bus.pll_switch_done && bus.pll_ready) begin
                    state_d = COMPLETE;
                    ack_d   = 1'b1;
                end
            end
            COMPLETE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                sw_d    = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            vco_q     <= VCO0;
            sw_q      <= 1'b0;
            cnt_q     <= 4'd0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vco_q     <= vco_d;
            sw_q      <= sw_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            ack_err_q <= ack_err_d;
        end
    end

    assign bus.core_vco_sel     = vco_q;
    assign bus.core_switch_vco  = sw_q;
    assign bus.busy             = busy_q;
    assign bus.ack              = ack_q;
    assign bus.ack_err          = ack_err_q;
    assign bus.lol_count        = lol_q;
    assign bus.switch_fsm_state = state_q;

endmodule
